// File: rtl/result_collector_pkg.sv
// ---------------------------------------------------------------------------
// result_collector_pkg
// Shared configuration for the result collector: default geometry of the
// systolic result stream, the row/entry types buffered by the row FIFO and
// a small helper that sizes the row counter.
// ---------------------------------------------------------------------------
package result_collector_pkg;

  localparam int sys_cols      = 4;  // result columns
  localparam int P_BITWIDTH    = 8;  // bits per result element
  localparam int A_rows        = 4;  // result rows per tile
  localparam int RC_FIFO_DEPTH = 8;  // row entries buffered

  typedef logic [sys_cols-1:0][P_BITWIDTH-1:0] row_t;

  typedef struct packed {
    row_t data;
    logic last;
  } rc_entry_t;

  // Row counter width; a single-row tile still needs one bit.
  function automatic int rc_cnt_width(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// ---------------------------------------------------------------------------
// result_fifo
// Synchronous first-word-fall-through FIFO for assembled result rows.
// The head entry is visible on dout whenever empty=0.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   push, din       write request and entry
//   pop             read request (ignored while empty)
//   dout            head entry (undefined while empty)
//   full, empty     occupancy flags
//   level           number of stored entries
// A push while full is accepted only if a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module result_fifo
  import result_collector_pkg::*;
#(
  parameter int  DEPTH   = RC_FIFO_DEPTH,
  parameter type entry_t = rc_entry_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  entry_t                       din,
  input  logic                         pop,
  output entry_t                       dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  entry_t      mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = LW'(wr_ptr_reg - rd_ptr_reg);
  assign dout    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  // Storage needs no reset: stale entries are never visible once the
  // pointers are cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

endmodule

// File: rtl/result_collector.sv
// ---------------------------------------------------------------------------
// result_collector
// Drain-side receiver for the systolic datapath. Reassembles skewed
// per-column results into complete rows, buffers them in a FWFT FIFO and
// presents them on a ready/valid stream, tagging the last row of each tile.
// The datapath cannot be stalled, so overflow and protocol problems are
// reported through sticky error flags instead of back-pressure.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   read_out        per-column result valid
//   o_data          per-column result data
//   rd_nxt_inst     one-cycle end-of-tile marker
//   m_valid/m_ready output row handshake
//   m_data, m_last  output row and last-row-of-tile tag (0 while idle)
//   tile_done       pulse the cycle after a last row is accepted
//   level           FIFO occupancy
//   err             sticky flags: [0] overflow, [1] collision/short tile
//   clr_err         clears err (a same-cycle new error still sets)
// ---------------------------------------------------------------------------
module result_collector #(
  parameter int SYS_COLS   = result_collector_pkg::sys_cols,
  parameter int P_BITWIDTH = result_collector_pkg::P_BITWIDTH,
  parameter int A_ROWS     = result_collector_pkg::A_rows,
  parameter int FIFO_DEPTH = result_collector_pkg::RC_FIFO_DEPTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [SYS_COLS-1:0]                  read_out,
  input  logic [SYS_COLS-1:0][P_BITWIDTH-1:0]  o_data,
  input  logic                                 rd_nxt_inst,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [SYS_COLS-1:0][P_BITWIDTH-1:0]  m_data,
  output logic                                 m_last,
  output logic                                 tile_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      level,
  output logic [1:0]                           err,
  input  logic                                 clr_err
);

  import result_collector_pkg::rc_cnt_width;

  localparam int              CW       = rc_cnt_width(A_ROWS);
  localparam logic [CW-1:0]   LAST_ROW = CW'(A_ROWS-1);

  typedef logic [SYS_COLS-1:0][P_BITWIDTH-1:0] row_bus_t;
  typedef struct packed {
    row_bus_t data;
    logic     last;
  } entry_bus_t;

  logic [SYS_COLS-1:0]    filled_reg;
  logic [SYS_COLS-1:0]    filled_next;
  logic [P_BITWIDTH-1:0]  cap_reg [SYS_COLS];
  row_bus_t               merged_row;
  logic [CW-1:0]          row_cnt_reg;
  logic [CW-1:0]          row_cnt_next;
  logic [1:0]             err_reg;
  logic [1:0]             err_next;
  logic                   tile_done_reg;

  logic                   row_complete;
  logic                   row_is_last;
  logic                   collision;
  logic                   short_tile;
  logic                   overflow;

  entry_bus_t             push_entry;
  entry_bus_t             head_entry;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;

  // ---- Assembly stage: one capture register per column. A column whose
  // result arrives in the completing cycle bypasses its register so the
  // row can be pushed without an extra cycle.
  for (genvar gi = 0; gi < SYS_COLS; gi++) begin : g_col
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cap_reg[gi] <= '0;
      end else if (read_out[gi]) begin
        cap_reg[gi] <= o_data[gi];
      end
    end
    assign merged_row[gi] = read_out[gi] ? o_data[gi] : cap_reg[gi];
  end

  always_comb begin
    row_complete = &(filled_reg | read_out);
    collision    = |(filled_reg & read_out);
    row_is_last  = (row_cnt_reg == LAST_ROW);

    filled_next  = row_complete ? '0 : (filled_reg | read_out);
    row_cnt_next = row_cnt_reg;
    if (row_complete) begin
      row_cnt_next = row_is_last ? '0 : row_cnt_reg + CW'(1);
    end

    // End of tile is judged against the state after this cycle's updates,
    // so the final row of a tile arriving with rd_nxt_inst is not an error.
    short_tile = rd_nxt_inst && ((row_cnt_next != '0) || (|filled_next));
    if (short_tile) begin
      row_cnt_next = '0;
      filled_next  = '0;
    end

    overflow = row_complete && fifo_full && !fifo_pop;

    err_next = clr_err ? 2'b00 : err_reg;
    err_next = err_next | {collision || short_tile, overflow};

    push_entry.data = merged_row;
    push_entry.last = row_is_last;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filled_reg    <= '0;
      row_cnt_reg   <= '0;
      err_reg       <= '0;
      tile_done_reg <= 1'b0;
    end else begin
      filled_reg    <= filled_next;
      row_cnt_reg   <= row_cnt_next;
      err_reg       <= err_next;
      tile_done_reg <= fifo_pop && head_entry.last;
    end
  end

  // ---- Row buffer
  result_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_bus_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (row_complete),
    .din   (push_entry),
    .pop   (fifo_pop),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // ---- Output stream; head contents are masked while the FIFO is empty.
  assign m_valid   = !fifo_empty;
  assign fifo_pop  = m_valid && m_ready;
  assign m_data    = fifo_empty ? '0 : head_entry.data;
  assign m_last    = !fifo_empty && head_entry.last;
  assign tile_done = tile_done_reg;
  assign err       = err_reg;

endmodule

// File: doc/result_collector.md
# result_collector

Drain-side receiver for the systolic datapath. It consumes the per-column `read_out`/`o_data` result stream and reassembles skewed column outputs into complete rows. It buffers the rows in a small FIFO and presents them on a ready/valid stream to the output writer, tagging the last row of each tile. Overflow and protocol errors are flagged because the datapath cannot be back-pressured.

## Interface
Parameters:
- `SYS_COLS`, `sys_cols`: number of result columns.
- `P_BITWIDTH`, `P_BITWIDTH`: width of one result element.
- `A_ROWS`, `A_rows`: result rows per tile.
- `FIFO_DEPTH`, 8: row entries; power of two, at least 2.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `read_out`, in, `SYS_COLS`: per-column result valid.
- `o_data`, in, `SYS_COLS`x`P_BITWIDTH`: per-column result data.
- `rd_nxt_inst`, in, 1: one-cycle pulse marking end of tile accumulation.
- `m_valid`, out, 1: output row valid.
- `m_ready`, in, 1: downstream accept.
- `m_data`, out, `SYS_COLS`x`P_BITWIDTH`: output row.
- `m_last`, out, 1: row is row `A_ROWS-1` of its tile.
- `tile_done`, out, 1: one-cycle pulse when an `m_last` row is accepted.
- `level`, out, `$clog2(FIFO_DEPTH+1)`: FIFO occupancy.
- `err`, out, 2: sticky flags. Bit 0 is overflow; bit 1 is protocol (collision or short tile).
- `clr_err`, in, 1: synchronous clear of `err`.

## Operation
- **Assembly stage.** Each column has a capture register and a `filled` flag.
  - When `read_out[c]=1`, the stage captures `o_data[c]` and sets `filled[c]`.
  - A row is complete in the cycle where (`filled | read_out`) is all ones. The merged row is pushed that same cycle and all `filled` flags clear.
- **Collision.** If `read_out[c]=1` while `filled[c]` is already set, the stage sets `err[1]` and overwrites the element.
- **Row counter.** The counter runs 0..`A_ROWS-1` and increments on each complete row, whether or not the push succeeds. The row at index `A_ROWS-1` is stored with `last=1`, and the counter then wraps to 0.
- **FIFO.** Read and write pointers are `$clog2(FIFO_DEPTH)+1` bits wide; the extra bit is the wrap bit.
  - Full means the pointers are equal except for the wrap bit. Empty means the pointers are fully equal.
- **Output.** The FIFO is first-word-fall-through.
  - `m_valid` is high exactly when the FIFO is not empty.
  - `m_data` and `m_last` come from the head entry and are forced to 0 when the FIFO is empty.
  - A pop happens when `m_valid && m_ready`.
- **Overflow.** A push while full with no pop in the same cycle drops the row and sets `err[0]`. A push while full with a pop in the same cycle is accepted.
- **tile_done.** Pulses for one cycle in the cycle after a pop of a `last` entry.
- **rd_nxt_inst.** The row counter is evaluated after any same-cycle increment.
  - If the row counter is not 0, or any `filled` bit is set, the block sets `err[1]`, resets the row counter to 0 and clears `filled`.
  - Otherwise `rd_nxt_inst` has no effect.
- **Error flags.** `clr_err` clears `err`. If a new error condition occurs in the same cycle as `clr_err`, the error wins.

## Timing
- **Reset values:**
  - Outputs: `m_valid`=0, `m_data`=0, `m_last`=0, `tile_done`=0, `level`=0, `err`=0.
  - Internal state: pointers, row counter and `filled` are all cleared.
- **Mid-operation reset.** Reset applied mid-operation discards all FIFO contents and any partial row immediately, without waiting for a clock edge.
- **Latency.** A row completing in cycle N produces `m_valid`=1 in cycle N+1, with that row at the head if the FIFO was empty.
- **Throughput.** One row push and one row pop per cycle.
- **level.** Updates in the cycle after each push or pop. A simultaneous push and pop leaves it unchanged.
- **m_ready.** May change freely. While `m_valid`=1 and `m_ready`=0, `m_data` and `m_last` hold stable.

## Structure
- **Config package additions:**
  - `RC_FIFO_DEPTH` constant.
  - `typedef logic [sys_cols-1:0][P_BITWIDTH-1:0] row_t`.
  - `typedef struct packed {row_t data; logic last;} rc_entry_t`.
- **Sub-module `result_fifo`.** Parameterised synchronous FIFO of `rc_entry_t`, first-word-fall-through, with full/empty/level outputs.
- **Top level.** `result_collector` contains the assembly stage, the row counter, the error logic and the `tile_done` register.

## Test plan
1. **Unskewed row.** Set `SYS_COLS`=4 and `m_ready`=1. Assert all `read_out` bits in one cycle with data 1,2,3,4. Expect `m_valid`=1 the next cycle with `m_data`={4,3,2,1} for exactly one cycle and `err`=0.
2. **Skewed columns.** Assert `read_out[0..3]` on cycles 0,1,2,3 with data 10..13. Expect one row {13,12,11,10}, valid at cycle 4, and no collision.
3. **Full tile.** Set `A_ROWS`=4 and stream 4 complete rows. Expect `m_last`=1 only on the 4th row and `tile_done` pulsing one cycle after it is accepted. A following `rd_nxt_inst` leaves `err` at 0.
4. **Backpressure and overflow.** Set `FIFO_DEPTH`=8, hold `m_ready`=0 and push 9 rows. Expect `level`=8, `err[0]`=1, and the 9th row dropped.
   - Then release `m_ready`: the 8 original rows drain in order.
   - A push while full with a same-cycle pop is accepted, with no error.
5. **Protocol errors.**
   - A second `read_out[2]` before the row completes sets `err[1]`.
   - `rd_nxt_inst` after only 2 of 4 rows sets `err[1]` and resets the row counter, so the next row is row 0.
   - `clr_err` then returns `err` to 0.
6. **Reset mid-stream.** Drive `rst`=0 with 3 rows queued and a partial row assembled. Expect `m_valid`, `level` and `err` to go to 0 immediately. After release, a complete row emerges cleanly as row 0.
